// File: rtl/inst_decode_unit.sv
// inst_decode_unit: instruction/memory data registers and instruction decode
// for the multicycle control FSM. Instruction SRAM data is bypassed into the
// decoder on the cycle it returns, so the FSM can dispatch without waiting a
// cycle. Load data is captured into the MDR one cycle after a read strobe.
//
// Optional feature: define INST_DECODE_RETIRE_CNT_EN to add the 32-bit
// retire_cnt output, which counts IR captures and wraps to zero.
module inst_decode_unit #(
    parameter logic [31:0] IR_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_mem_en,
    input  logic [31:0] inst_rdata,
    input  logic        data_mem_en,
    input  logic [3:0]  data_mem_wen,
    input  logic [31:0] data_rdata,
    output logic [6:0]  extend_inst,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic [4:0]  rd_addr,
    output logic [4:0]  sa,
    output logic [31:0] imm_sext,
    output logic [31:0] br_offset,
    output logic [25:0] jump_index,
    output logic [31:0] mdr,
    output logic        illegal_inst,
    output logic        illegal_seen
`ifdef INST_DECODE_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    logic        r_fetch_pend;
    logic        r_rd_pend;
    logic [31:0] r_ir;
    logic [31:0] r_mdr;
    logic        r_illegal_seen;

    logic [31:0] w_word;
    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [6:0]  w_ext;
    logic        w_illegal;

    // Track outstanding SRAM reads: each SRAM returns data one cycle after its strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pend <= 1'b0;
            r_rd_pend    <= 1'b0;
        end else begin
            r_fetch_pend <= inst_mem_en;
            r_rd_pend    <= data_mem_en && (data_mem_wen == 4'b0000);
        end
    end

    // Capture the returned instruction; reset discards a word still in flight.
    always_ff @(posedge clk) begin
        if (reset)
            r_ir <= IR_RESET;
        else if (r_fetch_pend)
            r_ir <= inst_rdata;
    end

    // Capture load data; write cycles never arm r_rd_pend so the MDR holds.
    always_ff @(posedge clk) begin
        if (reset)
            r_mdr <= 32'h0000_0000;
        else if (r_rd_pend)
            r_mdr <= data_rdata;
    end

    // Sticky record of any unsupported instruction reaching the decoder.
    always_ff @(posedge clk) begin
        if (reset)
            r_illegal_seen <= 1'b0;
        else if (w_illegal)
            r_illegal_seen <= 1'b1;
    end

`ifdef INST_DECODE_RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;

    // Count every IR capture; natural 32-bit wrap.
    always_ff @(posedge clk) begin
        if (reset)
            r_retire_cnt <= 32'h0000_0000;
        else if (r_fetch_pend)
            r_retire_cnt <= r_retire_cnt + 32'd1;
    end

    assign retire_cnt = r_retire_cnt;
`endif

    // Decode the bypassed SRAM word in the return cycle, otherwise the IR.
    always_comb begin
        w_word   = r_fetch_pend ? inst_rdata : r_ir;
        w_opcode = w_word[31:26];
        w_funct  = w_word[5:0];
        w_ext    = (w_opcode == 6'd0) ? {1'b0, w_funct} : {1'b1, w_opcode};
        case (w_ext)
            7'b1001111, // LUI
            7'b0100001, // ADDU
            7'b1001001, // ADDIU
            7'b1000100, // BEQ
            7'b1000101, // BNE
            7'b1100011, // LW
            7'b0100101, // OR
            7'b0101010, // SLT
            7'b1001010, // SLTI
            7'b1001011, // SLTIU
            7'b0000000, // SLL
            7'b1101011, // SW
            7'b1000010, // J
            7'b1000011, // JAL
            7'b0001000: // JR
                w_illegal = 1'b0;
            default:
                w_illegal = 1'b1;
        endcase
    end

    assign extend_inst  = w_ext;
    assign rs_addr      = w_word[25:21];
    assign rt_addr      = w_word[20:16];
    assign rd_addr      = w_word[15:11];
    assign sa           = w_word[10:6];
    assign imm_sext     = {{16{w_word[15]}}, w_word[15:0]};
    assign br_offset    = {{14{w_word[15]}}, w_word[15:0], 2'b00};
    assign jump_index   = w_word[25:0];
    assign mdr          = r_mdr;
    assign illegal_inst = w_illegal;
    assign illegal_seen = r_illegal_seen;

endmodule
